uart_rx_frame_parser: RTL

//  Downstream consumer of the UART receive path. Pops bytes from the UART RX FIFO
//  (drives CPU_read, samples data_out) and parses frames: SOF, LEN, LEN payload bytes.

---
 rtl/uart_rx_frame_parser.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_parser.sv
// Pops bytes from the UART RX FIFO and parses SOF / LEN / payload frames, streaming payload on valid/ready.
// Defining PARSER_CHECKSUM_EN adds a trailing XOR checksum byte (over LEN and payload) to each frame.
module uart_rx_frame_parser #(
    parameter logic [7:0] SOF_BYTE       = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 500_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx_empty,
    input  logic [7:0] i_rx_data,
    output logic       o_rx_read,
    output logic [7:0] o_pl_data,
    output logic       o_pl_valid,
    output logic       o_pl_last,
    input  logic       i_pl_ready,
    output logic       o_frame_ok,
    output logic       o_frame_err,
    output logic [1:0] o_err_code
);
    localparam int              CW        = $clog2(MAX_LEN + 1);
    localparam int              TW        = $clog2(TIMEOUT_CYCLES);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

`ifdef PARSER_CHECKSUM_EN
    typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CSUM} state_t;
`else
    typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD} state_t;
`endif

    state_t          r_state;
    logic            r_rd_pend;
    logic [7:0]      r_pl_data;
    logic            r_pl_valid;
    logic            r_pl_last;
    logic            r_frame_ok;
    logic            r_frame_err;
    logic [1:0]      r_err_code;
    logic [CW-1:0]   r_len;
    logic [CW-1:0]   r_cnt;
    logic [TW-1:0]   r_tmo;
`ifdef PARSER_CHECKSUM_EN
    logic [7:0]      r_csum;
`endif

    logic w_allowed;
    logic w_tmo_hit;
    logic w_hs;
    logic w_fetch;

    assign w_hs      = r_pl_valid && i_pl_ready;
    assign w_allowed = (r_state != S_PAYLOAD) || !r_pl_valid;
    // The timeout cycle aborts the frame, so no new pop is started in it.
    assign w_tmo_hit = (r_state != S_HUNT) && !r_rd_pend && !r_pl_valid && (r_tmo == TMO_LAST);
    assign w_fetch   = !i_reset && !i_rx_empty && !r_rd_pend && w_allowed && !w_tmo_hit;

    assign o_rx_read   = w_fetch;
    assign o_pl_data   = r_pl_data;
    assign o_pl_valid  = r_pl_valid;
    assign o_pl_last   = r_pl_last;
    assign o_frame_ok  = r_frame_ok;
    assign o_frame_err = r_frame_err;
    assign o_err_code  = r_err_code;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_HUNT;
            r_rd_pend   <= 1'b0;
            r_pl_data   <= 8'd0;
            r_pl_valid  <= 1'b0;
            r_pl_last   <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= 2'd0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_tmo       <= '0;
`ifdef PARSER_CHECKSUM_EN
            r_csum      <= 8'd0;
`endif
        end else begin
            r_rd_pend   <= w_fetch;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= 2'd0;

            if (w_hs) begin
                r_pl_valid <= 1'b0;
                r_pl_last  <= 1'b0;
                if (r_pl_last) begin
`ifdef PARSER_CHECKSUM_EN
                    r_state <= S_CSUM;
`else
                    r_frame_ok <= 1'b1;
                    r_state    <= S_HUNT;
`endif
                end
            end

            // Downstream stalls freeze the counter; only a starved FIFO counts.
            if (r_state == S_HUNT || r_rd_pend) begin
                r_tmo <= '0;
            end else if (!r_pl_valid) begin
                if (w_tmo_hit) begin
                    r_tmo       <= '0;
                    r_frame_err <= 1'b1;
                    r_err_code  <= 2'd3;
                    r_state     <= S_HUNT;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end

            if (r_rd_pend) begin
                case (r_state)
                    S_HUNT: begin
                        if (i_rx_data == SOF_BYTE) r_state <= S_LEN;
                    end
                    S_LEN: begin
                        if (i_rx_data == 8'd0 || i_rx_data > MAX_LEN_B) begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= 2'd1;
                            r_state     <= S_HUNT;
                        end else begin
                            r_len   <= i_rx_data[CW-1:0];
                            r_cnt   <= '0;
                            r_state <= S_PAYLOAD;
`ifdef PARSER_CHECKSUM_EN
                            r_csum  <= i_rx_data;
`endif
                        end
                    end
                    S_PAYLOAD: begin
                        r_pl_data  <= i_rx_data;
                        r_pl_valid <= 1'b1;
                        r_pl_last  <= (r_cnt + 1'b1 == r_len);
                        r_cnt      <= r_cnt + 1'b1;
`ifdef PARSER_CHECKSUM_EN
                        r_csum     <= r_csum ^ i_rx_data;
`endif
                    end
`ifdef PARSER_CHECKSUM_EN
                    S_CSUM: begin
                        if (i_rx_data == r_csum) begin
                            r_frame_ok <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= 2'd2;
                        end
                        r_state <= S_HUNT;
                    end
`endif
                    default: r_state <= S_HUNT;
                endcase
            end
        end
    end
endmodule
